// File: rtl/expr_pkg.sv
// Shared constants for the expression checker/evaluator pair: ASCII codes,
// FSM state encoding and character-class codes.
package expr_pkg;
    localparam logic [7:0] CH_0   = 8'd48;
    localparam logic [7:0] CH_9   = 8'd57;
    localparam logic [7:0] CH_ADD = 8'd43;
    localparam logic [7:0] CH_MUL = 8'd42;

    typedef enum logic [1:0] {S_NUM, S_OP, S_FLUSH, S_RES} state_e;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_DIGIT = 2'd1,
        CLS_OP    = 2'd2
    } cls_e;
endpackage

// File: rtl/expr_eval_if.sv
// Character-in / result-out handshake bundle for the expression evaluator.
interface expr_eval_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_value;
    logic             res_error;
    logic             res_ready;

    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, res_valid, res_value, res_error
    );

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, res_valid, res_value, res_error
    );
endinterface

// File: rtl/expr_char_class.sv
// Combinational character classifier: digit / operator / other, plus digit value.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0] data_i,
    output cls_e       cls_o,
    output logic [3:0] digit_o
);
    logic [7:0] offs;

    // digit_o is only meaningful when cls_o == CLS_DIGIT
    assign offs    = data_i - CH_0;
    assign digit_o = offs[3:0];

    always_comb begin
        cls_o = CLS_OTHER;
        if (data_i >= CH_0 && data_i <= CH_9)
            cls_o = CLS_DIGIT;
        else if (data_i == CH_ADD || data_i == CH_MUL)
            cls_o = CLS_OP;
    end
endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for digit/'+'/'*' expressions with '*' precedence:
// sum holds finished terms, prod the term being built, mul_pend a pending '*'.
module expr_eval
    import expr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic       clk,
    input logic       clr,
    expr_eval_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d, prod_q, prod_d, val_q, val_d;
    logic             mul_q, mul_d, err_q, err_d;

    cls_e             cls;
    logic [3:0]       digit;
    logic [WIDTH-1:0] dig_w, prod_new;
    logic             accept, good_end;

    expr_char_class u_cls (
        .data_i  (bus.in_data),
        .cls_o   (cls),
        .digit_o (digit)
    );

    assign bus.in_ready  = (state_q != S_RES);
    assign bus.res_valid = (state_q == S_RES);
    assign bus.res_value = val_q;
    assign bus.res_error = err_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign dig_w    = WIDTH'(digit);
    assign prod_new = mul_q ? prod_q * dig_w : dig_w;
    // The only well-formed ending is a digit that closes the expression
    assign good_end = (state_q == S_NUM) && (cls == CLS_DIGIT);

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                S_NUM: begin
                    if (cls == CLS_DIGIT) state_d = bus.in_last ? S_RES : S_OP;
                    else                  state_d = bus.in_last ? S_RES : S_FLUSH;
                end
                S_OP: begin
                    if (bus.in_last)        state_d = S_RES;
                    else if (cls == CLS_OP) state_d = S_NUM;
                    else                    state_d = S_FLUSH;
                end
                S_FLUSH: if (bus.in_last) state_d = S_RES;
                default: state_d = state_q;
            endcase
        end else if (state_q == S_RES && bus.res_ready) begin
            state_d = S_NUM;
        end
    end

    always_comb begin
        sum_d  = sum_q;
        prod_d = prod_q;
        mul_d  = mul_q;
        val_d  = val_q;
        err_d  = err_q;
        if (accept) begin
            if (good_end) prod_d = prod_new;
            if (state_q == S_OP && cls == CLS_OP && !bus.in_last) begin
                if (bus.in_data == CH_ADD) begin
                    sum_d = sum_q + prod_q;
                    mul_d = 1'b0;
                end else begin
                    mul_d = 1'b1;
                end
            end
            if (state_d == S_RES) begin
                val_d = (good_end && bus.in_last) ? sum_q + prod_new : '0;
                err_d = !(good_end && bus.in_last);
            end
        end else if (state_q == S_RES && bus.res_ready) begin
            sum_d  = '0;
            prod_d = '0;
            mul_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= S_NUM;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sum_q  <= '0;
            prod_q <= '0;
            mul_q  <= 1'b0;
            val_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            prod_q <= prod_d;
            mul_q  <= mul_d;
            val_q  <= val_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_expr_eval.sv
// Directed bench: a 16-bit and an 8-bit evaluator fed the same character stream.
module tb_expr_eval;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_last = 1'b0;
    logic       res_ready = 1'b0;
    int         vectors = 0;
    int         errors = 0;

    expr_eval_if #(.WIDTH(16)) b16 ();
    expr_eval_if #(.WIDTH(8))  b8 ();

    assign b16.in_valid = in_valid;  assign b8.in_valid = in_valid;
    assign b16.in_data  = in_data;   assign b8.in_data  = in_data;
    assign b16.in_last  = in_last;   assign b8.in_last  = in_last;
    assign b16.res_ready = res_ready; assign b8.res_ready = res_ready;

    expr_eval #(.WIDTH(16)) dut16 (.clk(clk), .clr(clr), .bus(b16));
    expr_eval #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(b8));

    always #5 clk = ~clk;

    task automatic send_ch(input logic [7:0] c, input logic last);
        int n = 0;
        in_valid = 1'b1; in_data = c; in_last = last;
        while (!b16.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (n == 20) begin
            vectors++; errors++;
            $display("FAIL send_timeout in_ready=%0b required=1", b16.in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_ch(s[i], i == s.len() - 1);
    endtask

    task automatic take();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (b16.res_valid !== 1'b0 || b16.res_value !== 16'd0 || b16.res_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b val=%0d e=%0b exp 0/0/0",
                     b16.res_valid, b16.res_value, b16.res_error);
        end
        @(posedge clk); #1; clr = 1'b0; #1;
        vectors++;
        if (b16.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%0b exp=1", b16.in_ready);
        end
    endtask

    task automatic test_basic();
        send_str("1+2*3");
        vectors++;
        if (b16.res_valid !== 1'b1 || b16.res_value !== 16'd7 || b16.res_error !== 1'b0) begin
            errors++;
            $display("FAIL basic_1+2*3 got v=%0b val=%0d e=%0b exp 1/7/0",
                     b16.res_valid, b16.res_value, b16.res_error);
        end
        take();
        vectors++;
        if (b16.res_valid !== 1'b0 || b16.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release got v=%0b rdy=%0b exp 0/1", b16.res_valid, b16.in_ready);
        end
    endtask

    task automatic test_wrap();
        send_str("9*9*9");
        vectors++;
        if (b8.res_value !== 8'd217 || b8.res_error !== 1'b0) begin
            errors++; $display("FAIL wrap8_9*9*9 got=%0d e=%0b exp=217/0", b8.res_value, b8.res_error);
        end
        vectors++;
        if (b16.res_value !== 16'd729) begin
            errors++; $display("FAIL wrap16_9*9*9 got=%0d exp=729", b16.res_value);
        end
        take();
        send_str("9*9*9*9*9*9");
        vectors++;
        if (b16.res_value !== 16'd7153 || b8.res_value !== 8'd241) begin
            errors++;
            $display("FAIL wrap_9^6 got16=%0d got8=%0d exp 7153/241", b16.res_value, b8.res_value);
        end
        take();
        send_str("9*9*9+9*9*9");
        vectors++;
        if (b16.res_value !== 16'd1458 || b8.res_value !== 8'd178) begin
            errors++;
            $display("FAIL wrap_sum got16=%0d got8=%0d exp 1458/178", b16.res_value, b8.res_value);
        end
        take();
    endtask

    task automatic test_trailing_op();
        send_str("1+");
        vectors++;
        if (b16.res_valid !== 1'b1 || b16.res_error !== 1'b1 || b16.res_value !== 16'd0) begin
            errors++;
            $display("FAIL trailing_op got v=%0b e=%0b val=%0d exp 1/1/0",
                     b16.res_valid, b16.res_error, b16.res_value);
        end
        take();
        send_str("7");
        vectors++;
        if (b16.res_value !== 16'd7 || b16.res_error !== 1'b0) begin
            errors++; $display("FAIL after_err_7 got=%0d e=%0b exp 7/0", b16.res_value, b16.res_error);
        end
        take();
        send_str("12");
        vectors++;
        if (b16.res_error !== 1'b1 || b16.res_value !== 16'd0) begin
            errors++; $display("FAIL two_digits got e=%0b val=%0d exp 1/0", b16.res_error, b16.res_value);
        end
        take();
        send_str("+");
        vectors++;
        if (b16.res_error !== 1'b1 || b16.res_value !== 16'd0) begin
            errors++; $display("FAIL lone_op got e=%0b val=%0d exp 1/0", b16.res_error, b16.res_value);
        end
        take();
    endtask

    task automatic test_flush();
        send_ch("1", 1'b0);
        send_ch("a", 1'b0);
        vectors++;
        if (b16.res_valid !== 1'b0 || b16.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_mid got v=%0b rdy=%0b exp 0/1", b16.res_valid, b16.in_ready);
        end
        send_ch("2", 1'b1);
        vectors++;
        if (b16.res_valid !== 1'b1 || b16.res_error !== 1'b1 || b16.res_value !== 16'd0) begin
            errors++;
            $display("FAIL flush_end got v=%0b e=%0b val=%0d exp 1/1/0",
                     b16.res_valid, b16.res_error, b16.res_value);
        end
        take();
        send_str("4*5+6");
        vectors++;
        if (b16.res_value !== 16'd26 || b16.res_error !== 1'b0) begin
            errors++; $display("FAIL after_flush_26 got=%0d e=%0b exp 26/0", b16.res_value, b16.res_error);
        end
        take();
    endtask

    task automatic test_backpressure();
        send_str("5");
        in_valid = 1'b1; in_data = "8"; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (b16.in_ready !== 1'b0 || b16.res_valid !== 1'b1 ||
                b16.res_value !== 16'd5 || b16.res_error !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got rdy=%0b v=%0b val=%0d e=%0b exp 0/1/5/0",
                         i, b16.in_ready, b16.res_valid, b16.res_value, b16.res_error);
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        vectors++;
        if (b16.in_ready !== 1'b1 || b16.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got rdy=%0b v=%0b exp 1/0", b16.in_ready, b16.res_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        vectors++;
        if (b16.res_valid !== 1'b1 || b16.res_value !== 16'd8) begin
            errors++;
            $display("FAIL held_char got v=%0b val=%0d exp 1/8", b16.res_valid, b16.res_value);
        end
        take();
    endtask

    task automatic test_gaps();
        send_ch("3", 1'b0);
        repeat (4) @(posedge clk);
        #1;
        send_ch("*", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send_ch("3", 1'b1);
        vectors++;
        if (b16.res_value !== 16'd9 || b16.res_error !== 1'b0) begin
            errors++; $display("FAIL gaps_3*3 got=%0d e=%0b exp 9/0", b16.res_value, b16.res_error);
        end
        take();
    endtask

    task automatic test_clr();
        send_str("9");
        clr = 1'b1; #1;
        vectors++;
        if (b16.res_valid !== 1'b0 || b16.res_value !== 16'd0) begin
            errors++;
            $display("FAIL clr_mid_result got v=%0b val=%0d exp 0/0", b16.res_valid, b16.res_value);
        end
        @(posedge clk); #1; clr = 1'b0;
        send_ch("3", 1'b0);
        send_ch("*", 1'b0);
        clr = 1'b1; #1;
        vectors++;
        if (b16.res_valid !== 1'b0) begin
            errors++; $display("FAIL clr_mid_expr got v=%0b exp 0", b16.res_valid);
        end
        @(posedge clk); #1; clr = 1'b0;
        send_ch("2", 1'b1);
        vectors++;
        if (b16.res_value !== 16'd2 || b16.res_error !== 1'b0) begin
            errors++; $display("FAIL clr_then_2 got=%0d e=%0b exp 2/0", b16.res_value, b16.res_error);
        end
        take();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_trailing_op();
        test_flush();
        test_backpressure();
        test_gaps();
        test_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
